// File: rtl/bus_regfile_if.sv
// bus_regfile_if: signal bundle between the bus controller and the
// destination register file of the 16-bit processor bus.
//   master modport: drives buswires, rin_en, rin, ain, gin, aluresult,
//                   incr_pc; observes r0..r7, a, g, wr_ack.
//   slave modport : the register file itself (the reverse directions).
interface bus_regfile_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] buswires;
   logic             rin_en;
   logic [2:0]       rin;
   logic             ain;
   logic             gin;
   logic [WIDTH-1:0] aluresult;
   logic             incr_pc;
   logic [WIDTH-1:0] r0;
   logic [WIDTH-1:0] r1;
   logic [WIDTH-1:0] r2;
   logic [WIDTH-1:0] r3;
   logic [WIDTH-1:0] r4;
   logic [WIDTH-1:0] r5;
   logic [WIDTH-1:0] r6;
   logic [WIDTH-1:0] r7;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] g;
   logic             wr_ack;

   modport master (
      output buswires, rin_en, rin, ain, gin, aluresult, incr_pc,
      input  r0, r1, r2, r3, r4, r5, r6, r7, a, g, wr_ack
   );

   modport slave (
      input  buswires, rin_en, rin, ain, gin, aluresult, incr_pc,
      output r0, r1, r2, r3, r4, r5, r6, r7, a, g, wr_ack
   );
endinterface

// File: rtl/bus_regfile.sv
// bus_regfile: destination side of the processor bus. Captures buswires
// into one general register r0..r7 (rin_en/rin), operand register a (ain),
// and loads result register g from aluresult (gin). All outputs come
// straight from flops, so a register written this cycle still shows its
// old value to the bus mux until the next cycle.
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high reset (r0..r6, a, g, wr_ack -> 0,
//         r7 -> PC_RESET)
//   bus - bus_regfile_if.slave (bus inputs, register outputs, wr_ack)
// Optional feature: define BUS_REGFILE_PC_INCR_EN to let incr_pc advance
// r7 by one (modulo 2^WIDTH); a bus write to r7 in the same cycle wins and
// the increment is dropped. Without the macro incr_pc is ignored and no
// incrementer exists.
module bus_regfile #(
   parameter int               WIDTH    = 16,
   parameter logic [WIDTH-1:0] PC_RESET = 16'h0000
) (
   input logic          clk,
   input logic          rst,
   bus_regfile_if.slave bus
);

   logic [WIDTH-1:0] regs_r [8];
   logic [WIDTH-1:0] regs_next_s [8];
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] g_r;
   logic             ack_r;

   // Next value of each general register: bus write, else r7 increment, else hold
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         regs_next_s[i] = regs_r[i];
         if (bus.rin_en && (bus.rin == 3'(i))) begin
            regs_next_s[i] = bus.buswires;
         end else begin
            regs_next_s[i] = regs_r[i];
         end
      end
`ifdef BUS_REGFILE_PC_INCR_EN
      // The bus write has priority; the increment is discarded, not stacked.
      if (bus.incr_pc && !(bus.rin_en && (bus.rin == 3'd7))) begin
         regs_next_s[7] = regs_r[7] + WIDTH'(1);
      end else begin
         regs_next_s[7] = regs_next_s[7];
      end
`endif
   end

`ifndef BUS_REGFILE_PC_INCR_EN
   logic unused_incr_pc_s;
   assign unused_incr_pc_s = bus.incr_pc;
`endif

   // Register bank, operand/result registers and write acknowledge
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 7; i++) begin
            regs_r[i] <= '0;
         end
         regs_r[7] <= PC_RESET;
         a_r       <= '0;
         g_r       <= '0;
         ack_r     <= 1'b0;
      end else begin
         for (int i = 0; i < 8; i++) begin
            regs_r[i] <= regs_next_s[i];
         end
         if (bus.ain) begin
            a_r <= bus.buswires;
         end else begin
            a_r <= a_r;
         end
         if (bus.gin) begin
            g_r <= bus.aluresult;
         end else begin
            g_r <= g_r;
         end
         // A lone increment is not a write and is not acknowledged.
         ack_r <= bus.rin_en | bus.ain | bus.gin;
      end
   end

   assign bus.r0     = regs_r[0];
   assign bus.r1     = regs_r[1];
   assign bus.r2     = regs_r[2];
   assign bus.r3     = regs_r[3];
   assign bus.r4     = regs_r[4];
   assign bus.r5     = regs_r[5];
   assign bus.r6     = regs_r[6];
   assign bus.r7     = regs_r[7];
   assign bus.a      = a_r;
   assign bus.g      = g_r;
   assign bus.wr_ack = ack_r;

endmodule

// File: tb/tb_bus_regfile.sv
// tb_bus_regfile: directed plus random stimulus for bus_regfile, checked
// against a cycle-level reference model of the register file kept in
// plain arrays. Follows the BUS_REGFILE_PC_INCR_EN build setting.
module tb_bus_regfile;
   localparam logic [15:0] PCR = 16'h0000;

   logic clk;
   logic rst;
   int   errors;
   int   checks;

   bus_regfile_if #(.WIDTH(16)) bus ();

   bus_regfile #(.WIDTH(16), .PC_RESET(PCR)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model state
   logic [15:0] m_r [8];
   logic [15:0] m_a;
   logic [15:0] m_g;
   logic        m_ack;

`ifdef BUS_REGFILE_PC_INCR_EN
   localparam bit INCR_ON = 1'b1;
`else
   localparam bit INCR_ON = 1'b0;
`endif

   function automatic logic [15:0] dut_reg(input int i);
      case (i)
         0: return bus.r0;
         1: return bus.r1;
         2: return bus.r2;
         3: return bus.r3;
         4: return bus.r4;
         5: return bus.r5;
         6: return bus.r6;
         default: return bus.r7;
      endcase
   endfunction

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("%s_r%0d", tag, i), dut_reg(i), m_r[i]);
      end
      check({tag, "_a"}, bus.a, m_a);
      check({tag, "_g"}, bus.g, m_g);
      check({tag, "_ack"}, {15'd0, bus.wr_ack}, {15'd0, m_ack});
   endtask

   // One clock: apply inputs, advance the model, compare every output.
   task automatic step(input logic r, input logic we, input logic [2:0] idx,
                       input logic [15:0] bw, input logic ai, input logic gi,
                       input logic [15:0] alu, input logic inc, input string tag);
      rst = r;
      bus.rin_en = we; bus.rin = idx; bus.buswires = bw;
      bus.ain = ai; bus.gin = gi; bus.aluresult = alu; bus.incr_pc = inc;
      @(posedge clk);
      if (r) begin
         for (int i = 0; i < 7; i++) m_r[i] = 16'h0000;
         m_r[7] = PCR;
         m_a = 16'h0000; m_g = 16'h0000; m_ack = 1'b0;
      end else begin
         if (we) m_r[idx] = bw;
         else if (INCR_ON && inc) m_r[7] = m_r[7] + 16'd1;
         if (INCR_ON && inc && we && idx != 3'd7) m_r[7] = m_r[7] + 16'd1;
         if (ai) m_a = bw;
         if (gi) m_g = alu;
         m_ack = we | ai | gi;
      end
      #1;
      check_all(tag);
   endtask

   task automatic idle(input string tag);
      step(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, tag);
   endtask

   initial begin
      errors = 0; checks = 0;
      for (int i = 0; i < 8; i++) m_r[i] = 16'hxxxx;
      rst = 1'b0;
      bus.rin_en = 1'b0; bus.rin = 3'd0; bus.buswires = 16'h0000;
      bus.ain = 1'b0; bus.gin = 1'b0; bus.aluresult = 16'h0000; bus.incr_pc = 1'b0;

      // reset
      step(1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, "reset");
      check("reset_r7_const", bus.r7, PCR);

      // fill r0..r7 with i*1111, wr_ack stays high through the burst
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b1, 3'(i), 16'(16'h1111 * i), 1'b0, 1'b0, 16'h0000, 1'b0, "fill");
         check("fill_ack_const", {15'd0, bus.wr_ack}, 16'd1);
      end
      for (int i = 0; i < 8; i++) check("fill_const", dut_reg(i), 16'(16'h1111 * i));
      idle("fill_idle");
      check("fill_ack_low", {15'd0, bus.wr_ack}, 16'd0);

      // a and g loaded in the same cycle
      step(1'b0, 1'b0, 3'd0, 16'hAAAA, 1'b1, 1'b1, 16'hBBBB, 1'b0, "ag");
      check("ag_a_const", bus.a, 16'hAAAA);
      check("ag_g_const", bus.g, 16'hBBBB);
      check("ag_r5_const", bus.r5, 16'h5555);

      // increment wrap, or ignored increment in the default build
      if (INCR_ON) begin
         step(1'b0, 1'b1, 3'd7, 16'hFFFE, 1'b0, 1'b0, 16'h0000, 1'b0, "pc_load");
         step(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, "inc1");
         check("inc1_const", bus.r7, 16'hFFFF);
         step(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, "inc2");
         check("inc2_const", bus.r7, 16'h0000);
         step(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, "inc3");
         check("inc3_const", bus.r7, 16'h0001);
         check("inc3_ack", {15'd0, bus.wr_ack}, 16'd0);
         step(1'b0, 1'b1, 3'd7, 16'h0010, 1'b0, 1'b0, 16'h0000, 1'b0, "pc10");
         step(1'b0, 1'b1, 3'd7, 16'h1234, 1'b0, 1'b0, 16'h0000, 1'b1, "wr_vs_inc");
         check("wr_vs_inc_const", bus.r7, 16'h1234);
      end else begin
         step(1'b0, 1'b1, 3'd7, 16'h0042, 1'b0, 1'b0, 16'h0000, 1'b0, "pc_load");
         for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, "noinc");
            check("noinc_const", bus.r7, 16'h0042);
            check("noinc_ack", {15'd0, bus.wr_ack}, 16'd0);
         end
      end

      // reset overrides a coincident write
      step(1'b0, 1'b1, 3'd3, 16'h5555, 1'b0, 1'b0, 16'h0000, 1'b0, "r3_load");
      step(1'b1, 1'b1, 3'd3, 16'h9999, 1'b1, 1'b1, 16'h7777, 1'b1, "rst_wr");
      check("rst_wr_r3", bus.r3, 16'h0000);
      check("rst_wr_r7", bus.r7, PCR);
      check("rst_wr_ack", {15'd0, bus.wr_ack}, 16'd0);
      // first write right after reset release
      step(1'b0, 1'b1, 3'd1, 16'hC0DE, 1'b0, 1'b0, 16'h0000, 1'b0, "post_rst");
      check("post_rst_r1", bus.r1, 16'hC0DE);

      // random traffic
      for (int n = 0; n < 300; n++) begin
         step(($urandom_range(0, 39) == 0), 1'($urandom), 3'($urandom),
              16'($urandom), 1'($urandom), 1'($urandom), 16'($urandom),
              1'($urandom), "rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
